// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI byte sequencer and its FIFOs.
// Byte-oriented: every data path here is one byte wide.
package spi_pkg;

  localparam int BYTE_W          = 8;
  localparam int WDOG_W          = 10;
  localparam int DEFAULT_AW      = 4;
  localparam int DEFAULT_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_STORE     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/spi_byte_sequencer_if.sv
// Host-side byte streams of the sequencer: TX push and RX pop, valid/ready on both.
// master = register/command side, slave = sequencer.
interface spi_byte_sequencer_if;
  import spi_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Byte FIFO, 2**AW deep; push/pop take effect at the clock edge, head readable combinationally.
// push_rdy drops when full; flush empties it next cycle and overrides push/pop.
module sync_fifo
  import spi_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_vld,
  input  logic [BYTE_W-1:0] push_dat,
  output logic              push_rdy,
  input  logic              pop_rdy,
  output logic              pop_vld,
  output logic [BYTE_W-1:0] pop_dat,
  output logic [AW:0]       level
);

  localparam int DEPTH = 1 << AW;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              full, empty, push, pop;

  // The extra pointer bit tells full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push     = push_vld && !full;
  assign pop      = pop_rdy && !empty;
  assign push_rdy = !full;
  assign pop_vld  = !empty;
  assign pop_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level    = wr_ptr_q - rd_ptr_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_dat;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds the SPI master engine one byte per go pulse from a TX FIFO and captures replies into an RX FIFO.
// Issue stalls while RX is full (unless discarding); a watchdog aborts a transfer the engine never finishes.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  spi_byte_sequencer_if.slave  host,
  input  logic                 rx_discard,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic                 busy,
  output logic                 err,
  output logic [AW:0]          tx_level,
  output logic [AW:0]          rx_level,
  output logic                 spi_go,
  output logic [BYTE_W-1:0]    spi_wdata,
  input  logic                 spi_state,
  input  logic [BYTE_W-1:0]    spi_rdata
);

  localparam logic [WDOG_W-1:0] TIMEOUT_W = WDOG_W'(TIMEOUT);

  seq_state_e        state_q, state_d;
  logic              spi_go_q, spi_go_d;
  logic [BYTE_W-1:0] spi_wdata_q, spi_wdata_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [WDOG_W-1:0] wdog_inc;
  logic              abort;
  logic              tx_nonempty, rx_not_full, issue, rx_push;
  logic [BYTE_W-1:0] tx_head;

  sync_fifo #(.AW(AW)) u_tx_fifo (
    .clk      (clkin),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_vld (host.tx_valid),
    .push_dat (host.tx_data),
    .push_rdy (host.tx_ready),
    .pop_rdy  (issue),
    .pop_vld  (tx_nonempty),
    .pop_dat  (tx_head),
    .level    (tx_level)
  );

  sync_fifo #(.AW(AW)) u_rx_fifo (
    .clk      (clkin),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_vld (rx_push),
    .push_dat (spi_rdata),
    .push_rdy (rx_not_full),
    .pop_rdy  (host.rx_ready),
    .pop_vld  (host.rx_valid),
    .pop_dat  (host.rx_data),
    .level    (rx_level)
  );

  // Reserving RX space before issue means a reply can never overflow the RX FIFO.
  assign issue   = (state_q == ST_IDLE) && tx_nonempty && !spi_state &&
                   (rx_discard || rx_not_full) && !flush;
  assign rx_push = (state_q == ST_STORE) && !rx_discard && !drop_q;
  assign wdog_inc = wdog_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    spi_go_d    = 1'b0;
    spi_wdata_d = spi_wdata_q;
    wdog_d      = wdog_q;
    abort       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d     = ST_LOAD;
          spi_go_d    = 1'b1;
          spi_wdata_d = tx_head;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT_BUSY;
        wdog_d  = '0;
      end
      ST_WAIT_BUSY: begin
        if (spi_state) begin
          state_d = ST_WAIT_DONE;
          wdog_d  = '0;
        end else if (wdog_inc == TIMEOUT_W) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!spi_state) begin
          state_d = ST_STORE;
        end else if (wdog_inc == TIMEOUT_W) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      ST_STORE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush mid-transfer lets the byte finish on the bus but keeps its reply out of RX.
    drop_d = drop_q;
    if (state_d == ST_IDLE) begin
      drop_d = 1'b0;
    end else if (flush && (state_q inside {ST_LOAD, ST_WAIT_BUSY, ST_WAIT_DONE})) begin
      drop_d = 1'b1;
    end

    err_d = abort || (err_q && !clr_err);
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      spi_go_q    <= 1'b0;
      spi_wdata_q <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      spi_go_q    <= spi_go_d;
      spi_wdata_q <= spi_wdata_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      wdog_q      <= wdog_d;
    end
  end

  assign spi_go    = spi_go_q;
  assign spi_wdata = spi_wdata_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE) || tx_nonempty;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench: loopback engine model, byte-order scoreboard queues, and literal timing checks.
module tb_spi_byte_sequencer;

  localparam int AW      = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_discard, flush, clr_err;
  logic       busy, err, spi_go, spi_state;
  logic [AW:0] tx_level, rx_level;
  logic [7:0] spi_wdata, spi_rdata;

  spi_byte_sequencer_if host_if ();

  spi_byte_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clkin      (clk),
    .rst_n      (rst_n),
    .host       (host_if),
    .rx_discard (rx_discard),
    .flush      (flush),
    .clr_err    (clr_err),
    .busy       (busy),
    .err        (err),
    .tx_level   (tx_level),
    .rx_level   (rx_level),
    .spi_go     (spi_go),
    .spi_wdata  (spi_wdata),
    .spi_state  (spi_state),
    .spi_rdata  (spi_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_go     = 0;
  logic run = 1'b0;

  // Scoreboard: bytes accepted but not yet issued, and replies expected in RX order.
  logic [7:0] exp_issue [$];
  logic [7:0] exp_rx    [$];

  // Engine model state.
  logic       eng_mode = 1'b1;
  logic       eng_active = 1'b0;
  logic       drop_inflight = 1'b0;
  logic [7:0] eng_byte = '0;
  int         eng_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Loopback engine: busy for 4 cycles after go, returns the byte it was sent.
  initial begin
    spi_state = 1'b0;
    spi_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (eng_active) begin
        if (eng_cnt == 0) begin
          spi_state  = 1'b0;
          spi_rdata  = eng_byte;
          eng_active = 1'b0;
          if (!rx_discard && !drop_inflight) exp_rx.push_back(eng_byte);
          drop_inflight = 1'b0;
        end else begin
          eng_cnt--;
        end
      end else if (spi_go && eng_mode && rst_n) begin
        eng_byte   = spi_wdata;
        eng_active = 1'b1;
        spi_state  = 1'b1;
        eng_cnt    = 3;
      end
    end
  end

  // Per-cycle comparison against the scoreboard.
  initial begin
    logic prev_go;
    logic [7:0] exp_b;
    prev_go = 1'b0;
    forever begin
      @(negedge clk);
      if (run && rst_n) begin
        chk("go_single_cycle", prev_go && spi_go, 0);
        prev_go = spi_go;
        if (spi_go) begin
          n_go++;
          chk("go_has_byte", exp_issue.size() > 0, 1);
          if (exp_issue.size() > 0) begin
            exp_b = exp_issue.pop_front();
            chk("go_wdata", spi_wdata, exp_b);
          end
        end
        if (eng_active) chk("wdata_hold", spi_wdata, eng_byte);
        chk("tx_level", tx_level, exp_issue.size());
        chk("tx_ready", host_if.tx_ready, exp_issue.size() < DEPTH);
        chk("rx_valid", host_if.rx_valid, rx_level != 0);
        chk("rx_level_bound", rx_level <= exp_rx.size(), 1);
        if (host_if.rx_valid && exp_rx.size() > 0) chk("rx_head", host_if.rx_data, exp_rx[0]);
      end else begin
        prev_go = 1'b0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    host_if.tx_data  = b;
    host_if.tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      acc = host_if.tx_ready;
      @(posedge clk);
      if (acc) begin
        exp_issue.push_back(b);
        break;
      end
      #1;
    end
    chk("push_accepted", acc, 1);
    #1 host_if.tx_valid = 1'b0;
  endtask

  task automatic pop_one(output logic [7:0] d);
    logic acc;
    logic [7:0] e;
    acc = 1'b0;
    d = '0;
    host_if.rx_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      acc = host_if.rx_valid;
      d   = host_if.rx_data;
      @(posedge clk);
      if (acc) begin
        chk("rx_pop_expected", exp_rx.size() > 0, 1);
        if (exp_rx.size() > 0) begin
          e = exp_rx.pop_front();
          chk("rx_pop_data", d, e);
        end
        break;
      end
      #1;
    end
    chk("rx_pop_accepted", acc, 1);
    #1 host_if.rx_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    exp_issue.delete();
    exp_rx.delete();
    if (eng_active) drop_inflight = 1'b1;
    #1 flush = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy && !spi_state) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    int go_base;

    rst_n = 1'b0;
    rx_discard = 1'b0;
    flush = 1'b0;
    clr_err = 1'b0;
    host_if.tx_data = '0;
    host_if.tx_valid = 1'b0;
    host_if.rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_tx_ready", host_if.tx_ready, 1);
    chk("rst_rx_valid", host_if.rx_valid, 0);
    chk("rst_rx_data", host_if.rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_go", spi_go, 0);
    chk("rst_wdata", spi_wdata, 0);
    chk("rst_levels", {tx_level, rx_level}, 0);

    // Loopback: first go two cycles after the first push
    go_base = n_go;
    push_byte(8'hA5);
    @(negedge clk);
    chk("lb_no_go_yet", spi_go, 0);
    chk("lb_busy", busy, 1);
    push_byte(8'h3C);
    @(negedge clk);
    chk("lb_first_go", spi_go, 1);
    chk("lb_first_wdata", spi_wdata, 8'hA5);
    push_byte(8'hFF);
    wait_idle();
    chk("lb_go_count", n_go - go_base, 3);
    chk("lb_rx_level", rx_level, 3);
    pop_one(d); chk("lb_pop0", d, 8'hA5);
    pop_one(d); chk("lb_pop1", d, 8'h3C);
    pop_one(d); chk("lb_pop2", d, 8'hFF);
    @(negedge clk);
    chk("lb_rx_empty", rx_level, 0);

    // Write-only mode
    rx_discard = 1'b1;
    go_base = n_go;
    for (int i = 0; i < 20; i++) push_byte(8'(8'h40 + i));
    wait_idle();
    chk("wo_go_count", n_go - go_base, 20);
    chk("wo_rx_level", rx_level, 0);
    rx_discard = 1'b0;

    // RX full stalls issue
    go_base = n_go;
    for (int i = 0; i < 18; i++) push_byte(8'(8'h80 + 3 * i));
    wait_cycles(250);
    chk("full_go_count", n_go - go_base, 16);
    chk("full_rx_level", rx_level, 16);
    chk("full_tx_level", tx_level, 2);
    pop_one(d);
    chk("full_pop_first", d, 8'h80);
    wait_cycles(60);
    chk("full_one_more_go", n_go - go_base, 17);
    chk("full_tx_level2", tx_level, 1);
    for (int i = 0; i < 17; i++) pop_one(d);
    chk("full_last_byte", d, 8'(8'h80 + 3 * 17));
    wait_idle();
    chk("full_total_go", n_go - go_base, 18);
    chk("full_drained", rx_level, 0);

    // Flush while the first byte is in WAIT_DONE
    go_base = n_go;
    push_byte(8'h11);
    push_byte(8'h22);
    for (int i = 0; i < 50 && !spi_state; i++) @(negedge clk);
    wait_cycles(2);
    do_flush();
    @(negedge clk);
    chk("fl_tx_level", tx_level, 0);
    chk("fl_bus_still_busy", spi_state, 1);
    wait_idle();
    chk("fl_rx_level", rx_level, 0);
    chk("fl_go_count", n_go - go_base, 1);
    wait_cycles(5);
    chk("fl_busy", busy, 0);

    // Watchdog with a dead engine
    eng_mode = 1'b0;
    push_byte(8'h55);
    @(negedge clk);
    chk("wd_no_go_yet", spi_go, 0);
    @(negedge clk);
    chk("wd_go", spi_go, 1);
    wait_cycles(TIMEOUT);
    chk("wd_err_not_yet", err, 0);
    chk("wd_busy_waiting", busy, 1);
    @(negedge clk);
    chk("wd_err_set", err, 1);
    chk("wd_idle", busy, 0);
    chk("wd_rx_level", rx_level, 0);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
    chk("wd_err_cleared", err, 0);
    eng_mode = 1'b1;

    // Reset in WAIT_DONE with three bytes still queued
    for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i));
    for (int i = 0; i < 50 && !spi_state; i++) @(negedge clk);
    wait_cycles(2);
    chk("rm_queued", tx_level, 3);
    rst_n = 1'b0;
    @(posedge clk);
    exp_issue.delete();
    exp_rx.delete();
    eng_active = 1'b0;
    drop_inflight = 1'b0;
    spi_state = 1'b0;
    #1 rst_n = 1'b1;
    go_base = n_go;
    @(negedge clk);
    chk("rm_tx_level", tx_level, 0);
    chk("rm_rx_level", rx_level, 0);
    chk("rm_busy", busy, 0);
    chk("rm_go", spi_go, 0);
    chk("rm_wdata", spi_wdata, 0);
    chk("rm_err", err, 0);
    chk("rm_tx_ready", host_if.tx_ready, 1);
    chk("rm_rx_valid", host_if.rx_valid, 0);
    wait_cycles(30);
    chk("rm_no_go_after", n_go - go_base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete within 300000 time units");
    $fatal(1);
  end

endmodule
